fetch_unit: RTL and testbench

//  Instruction fetch stage of the RISC-V core: owns the PC, issues word reads to

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory and
// buffers returned {pc, inst} pairs in a small FIFO feeding decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic [CW:0]   w_credit;
  logic          w_accept;
  logic          w_resp_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit covers buffered entries plus live in-flight fetches; dropped fetches
  // still hold an outstanding slot, so the outstanding counter is capped too.
  assign w_credit         = {1'b0, r_count} + {1'b0, r_outstanding} - {1'b0, r_drop};
  assign o_imem_req_valid = !i_rst && !i_redirect_valid && (w_credit < DEPTH_W)
                            && ({1'b0, r_outstanding} < DEPTH_W);
  assign o_imem_addr      = r_pc;

  assign w_accept      = o_imem_req_valid && i_imem_req_ready;
  assign w_resp_drop   = i_imem_resp_valid && (r_drop != '0);
  assign w_push        = i_imem_resp_valid && (r_drop == '0) && !i_redirect_valid && !i_rst;
  assign w_pop         = o_id_valid && i_id_ready;
  assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

  assign o_id_valid = (r_count != '0);
  assign o_id_inst  = o_id_valid ? r_fifo_inst[r_rd_ptr] : NOP;
  assign o_id_pc    = o_id_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (i_redirect_valid) begin
      // Everything still in flight becomes stale, including a response landing now.
      r_pc          <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= r_outstanding - CW'(i_imem_resp_valid);
      r_drop        <= r_outstanding - CW'(i_imem_resp_valid);
    end else begin
      if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(i_imem_resp_valid);
      if (w_resp_drop) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      r_fifo_inst[r_wr_ptr] <= i_imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model answers fetches,
// directed tests queue the expected {pc, inst} stream and a monitor checks each handoff.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [31:0] imemAddr;
  logic        respValid = 1'b0;
  logic [31:0] respData = 32'h0;
  logic        redirValid = 1'b0;
  logic [31:0] redirPc = 32'h0;
  logic        idValid;
  logic        idReady = 1'b0;
  logic [31:0] idInst;
  logic [31:0] idPc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_imem_req_valid  (reqValid),
    .i_imem_req_ready  (reqReady),
    .o_imem_addr       (imemAddr),
    .i_imem_resp_valid (respValid),
    .i_imem_resp_data  (respData),
    .i_redirect_valid  (redirValid),
    .i_redirect_pc     (redirPc),
    .o_id_valid        (idValid),
    .i_id_ready        (idReady),
    .o_id_inst         (idInst),
    .o_id_pc           (idPc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  exp_t        expQ[$];
  mreq_t       inflight[$];
  logic [31:0] acceptLog[$];
  int          nChecks = 0;
  int          nPass = 0;
  int          cyc = 0;
  int          memLat = 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h4D62_A303;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic rq, input logic ir,
                               input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst        = r;
    reqReady   = rq;
    idReady    = ir;
    redirValid = rv;
    redirPc    = rpc;
  endtask

  task automatic expectSeq(input logic [31:0] startPc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = startPc + 32'(4 * i);
      e.inst = memWord(e.pc);
      expQ.push_back(e);
    end
  endtask

  task automatic resetDut(input int lat);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    memLat = lat;
    expQ.delete();
    acceptLog.delete();
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (expQ.size() != 0 && n < budget);
    idReady = 1'b0;
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  function automatic logic [31:0] logAt(input int idx);
    if (acceptLog.size() > idx) return acceptLog[idx];
    return 32'hDEAD_BEEF;
  endfunction

  // Memory model: in-order responses exactly memLat cycles after each accept.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (inflight.size() != 0 && inflight[0].due == cyc) begin
      respValid = 1'b1;
      respData  = memWord(inflight[0].addr);
      void'(inflight.pop_front());
    end else begin
      respValid = 1'b0;
      respData  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      inflight.delete();
    end else if (reqValid && reqReady) begin
      inflight.push_back('{due: cyc + memLat, addr: imemAddr});
      acceptLog.push_back(imemAddr);
      checkOutput("outstandingBound", 32'(inflight.size() <= DEPTH), 32'd1);
    end
  end

  // Monitor: every accepted decode handoff must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst && !redirValid && idValid && idReady) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL unexpectedOutput: got pc 0x%08h inst 0x%08h, want none", idPc, idInst);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("idPc", idPc, e.pc);
        checkOutput("idInst", idInst, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [15:0] readyPattern;

  initial begin
    // Reset state
    resetDut(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rstReqValid", 32'(reqValid), 32'd0);
    checkOutput("rstIdValid", 32'(idValid), 32'd0);
    checkOutput("rstIdInst", idInst, NOP);
    checkOutput("rstIdPc", idPc, 32'h0);
    checkOutput("rstAddr", imemAddr, 32'h0);

    // Test 1: streaming with L=1
    $display("[TB] test 1: streaming fetch");
    expectSeq(32'h0, 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1ReqValid0", 32'(reqValid), 32'd1);
    checkOutput("t1Addr0", imemAddr, 32'h0);
    checkOutput("t1IdValidEarly0", 32'(idValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1Addr1", imemAddr, 32'h4);
    checkOutput("t1IdValidEarly1", 32'(idValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1IdValidFirst", 32'(idValid), 32'd1);
    checkOutput("t1IdPcFirst", idPc, 32'h0);
    waitDrain("t1Drain", 100);
    for (int i = 0; i < 4; i++) checkOutput("t1AddrSeq", logAt(i), 32'(4 * i));

    // Test 2: back-pressure fills the FIFO, then fetch resumes at 8
    $display("[TB] test 2: back-pressure");
    resetDut(1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2ReqStalled", 32'(reqValid), 32'd0);
    checkOutput("t2IdValid", 32'(idValid), 32'd1);
    checkOutput("t2AcceptCount", 32'(acceptLog.size()), 32'd2);
    checkOutput("t2Addr0", logAt(0), 32'h0);
    checkOutput("t2Addr1", logAt(1), 32'h4);
    expectSeq(32'h0, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitDrain("t2Drain", 100);
    checkOutput("t2ResumeAddr", logAt(2), 32'h8);

    // Test 3: redirect with two long-latency fetches outstanding
    $display("[TB] test 3: redirect drops in-flight fetches");
    resetDut(3);
    expectSeq(32'h100, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    @(negedge clk);
    checkOutput("t3NoReqOnRedirect", 32'(reqValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitDrain("t3Drain", 100);
    checkOutput("t3Addr0", logAt(0), 32'h0);
    checkOutput("t3Addr1", logAt(1), 32'h4);
    checkOutput("t3RedirAddr", logAt(2), 32'h100);

    // Test 4: redirect coincides with a response and a pop at count=1
    $display("[TB] test 4: redirect with response and pop");
    resetDut(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    @(negedge clk);
    checkOutput("t4IdValidBefore", 32'(idValid), 32'd1);
    checkOutput("t4RespPresent", 32'(respValid), 32'd1);
    checkOutput("t4NoReqOnRedirect", 32'(reqValid), 32'd0);
    expectSeq(32'h200, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4FifoFlushed", 32'(idValid), 32'd0);
    checkOutput("t4ReqAfter", 32'(reqValid), 32'd1);
    checkOutput("t4AddrAfter", imemAddr, 32'h200);
    waitDrain("t4Drain", 100);

    // Test 5: reset pulse mid-operation
    $display("[TB] test 5: reset mid-operation");
    resetDut(3);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5IdValidPreRst", 32'(idValid), 32'd1);
    checkOutput("t5ReqInRst", 32'(reqValid), 32'd0);
    acceptLog.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t5IdValid", 32'(idValid), 32'd0);
    checkOutput("t5IdInst", idInst, NOP);
    checkOutput("t5IdPc", idPc, 32'h0);
    checkOutput("t5Addr", imemAddr, 32'h0);
    checkOutput("t5ReqValid", 32'(reqValid), 32'd1);
    expectSeq(32'h0, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitDrain("t5Drain", 100);

    // Test 6: toggling memory ready with L=2 and irregular decode ready
    $display("[TB] test 6: toggling ready");
    resetDut(2);
    readyPattern = 16'b1011_0010_1110_0101;
    expectSeq(32'h0, 20);
    begin
      int i = 0;
      while (expQ.size() != 0 && i < 400) begin
        applyStimulus(1'b0, (i % 2) == 0, readyPattern[i % 16], 1'b0, 32'h0);
        i++;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t6Drain", 32'(expQ.size()), 32'd0);
    expQ.delete();
    for (int i = 0; i < 6; i++) checkOutput("t6AddrSeq", logAt(i), 32'(4 * i));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
